// File: rtl/gate_arbiter_pkg.sv
// Shared constants and types for the round-robin gate arbiter.
// No logic of its own; imported by gate_unit and gate_arbiter.
// Opcode values, FSM encoding and the latched per-operation context.
package gate_arbiter_pkg;

    localparam int NREQ = 4;

    localparam logic [1:0] OP_OR  = 2'b00;
    localparam logic [1:0] OP_AND = 2'b01;
    localparam logic [1:0] OP_XOR = 2'b10;
    localparam logic [1:0] OP_NOR = 2'b11;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EXEC = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    // Everything captured from the winning requester in the granting IDLE cycle.
    typedef struct packed {
        logic [1:0] idx;
        logic [1:0] op;
        logic       a;
        logic       b;
    } ctx_t;

    function automatic logic [NREQ-1:0] idx_onehot(input logic [1:0] idx);
        logic [NREQ-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/gate_unit.sv
// Shared single-bit gate: OR / AND / XOR / NOR selected by op.
// Latency: combinational.
// Backpressure: none.
module gate_unit
    import gate_arbiter_pkg::*;
(
    input  logic       a,
    input  logic       b,
    input  logic [1:0] op,
    output logic       y
);

    always_comb begin
        y = 1'b0;
        case (op)
            OP_OR:   y = a | b;
            OP_AND:  y = a & b;
            OP_XOR:  y = a ^ b;
            OP_NOR:  y = ~(a | b);
            default: y = 1'b0;
        endcase
    end

endmodule

// File: rtl/gate_arbiter.sv
// Round-robin arbiter sharing one gate_unit among NREQ requesters.
// Latency: gnt one cycle after the granting IDLE cycle, y_valid/ack one cycle later.
// Backpressure: losers simply keep req high; one operation per three cycles.
module gate_arbiter
    import gate_arbiter_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ-1:0]   a_in,
    input  logic [NREQ-1:0]   b_in,
    input  logic [2*NREQ-1:0] op_in,
    output logic [NREQ-1:0]   gnt,
    output logic [NREQ-1:0]   ack,
    output logic              y,
    output logic              y_valid,
    output logic              busy
);

    logic [1:0] state;
    logic [1:0] ptr;
    ctx_t       ctx;
    logic       gate_y;

    logic       found;
    logic [1:0] win;
    logic [1:0] cand;

    // First requesting index at or after ptr, wrapping modulo 4.
    always_comb begin
        found = 1'b0;
        win   = ptr;
        cand  = ptr;
        for (int k = 0; k < NREQ; k++) begin
            cand = ptr + k[1:0];
            if (!found && req[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
    end

    gate_unit u_gate (
        .a  (ctx.a),
        .b  (ctx.b),
        .op (ctx.op),
        .y  (gate_y)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            ptr     <= 2'd0;
            ctx     <= '0;
            gnt     <= '0;
            ack     <= '0;
            y       <= 1'b0;
            y_valid <= 1'b0;
            busy    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (found) begin
                        ctx.idx <= win;
                        ctx.op  <= op_in[{win, 1'b0} +: 2];
                        ctx.a   <= a_in[win];
                        ctx.b   <= b_in[win];
                        ptr     <= win + 2'd1;
                        gnt     <= idx_onehot(win);
                        busy    <= 1'b1;
                        state   <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    y       <= gate_y;
                    y_valid <= 1'b1;
                    ack     <= idx_onehot(ctx.idx);
                    state   <= ST_RESP;
                end
                ST_RESP: begin
                    // No bypass back into a grant: IDLE always gets its own cycle.
                    y_valid <= 1'b0;
                    ack     <= '0;
                    gnt     <= '0;
                    busy    <= 1'b0;
                    state   <= ST_IDLE;
                end
                default: begin
                    y_valid <= 1'b0;
                    ack     <= '0;
                    gnt     <= '0;
                    busy    <= 1'b0;
                    state   <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gate_arbiter.sv
// Bench for gate_arbiter: operation-level model checked every cycle plus directed scenarios.
module tb_gate_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req, a_in, b_in, gnt, ack;
    logic [7:0] op_in;
    logic       y, y_valid, busy;

    always #5 clk = ~clk;

    gate_arbiter dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .a_in    (a_in),
        .b_in    (b_in),
        .op_in   (op_in),
        .gnt     (gnt),
        .ack     (ack),
        .y       (y),
        .y_valid (y_valid),
        .busy    (busy)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic bit gate_ref(input bit a, input bit b, input bit [1:0] op);
        case (op)
            2'd0:    return a | b;
            2'd1:    return a & b;
            2'd2:    return a ^ b;
            default: return !(a | b);
        endcase
    endfunction

    function automatic int pick(input bit [3:0] r, input int p);
        for (int s = 0; s < 4; s++)
            if (r[(p + s) % 4]) return (p + s) % 4;
        return -1;
    endfunction

    // Operation model: an operation granted on clock edge k owns the block for
    // edges k..k+2; the next grant can happen on edge k+3 at the earliest.
    int k, m_start, m_w, m_ptr;
    bit m_active, m_y;

    initial begin
        k = 0; m_start = 0; m_w = 0; m_ptr = 0; m_active = 0; m_y = 0;
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                m_active = 0;
                m_ptr    = 0;
                k        = 0;
            end else begin
                int w;
                k++;
                if (m_active && k >= m_start + 3) m_active = 0;
                if (!m_active) begin
                    w = pick(req, m_ptr);
                    if (w >= 0) begin
                        m_active = 1;
                        m_start  = k;
                        m_w      = w;
                        m_y      = gate_ref(a_in[w], b_in[w], op_in[2*w +: 2]);
                        m_ptr    = (w + 1) % 4;
                    end
                end
            end
        end
    end

    int ack_idx_q[$];
    int ack_y_q[$];
    int ack_cyc_q[$];
    int gnt_cyc_q[$];
    int cyc;

    initial begin
        int exp_gnt, exp_ack, exp_yv, exp_busy, d;
        logic [3:0] prev_gnt;
        cyc = 0;
        prev_gnt = '0;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            exp_gnt = 0; exp_ack = 0; exp_yv = 0; exp_busy = 0;
            if (!rst && m_active) begin
                d = k - m_start;
                if (d <= 1) begin
                    exp_gnt  = 1 << m_w;
                    exp_busy = 1;
                end
                if (d == 1) begin
                    exp_ack = 1 << m_w;
                    exp_yv  = 1;
                end
            end
            check("gnt", int'(gnt), exp_gnt);
            check("ack", int'(ack), exp_ack);
            check("y_valid", int'(y_valid), exp_yv);
            check("busy", int'(busy), exp_busy);
            if (exp_yv != 0) check("y", int'(y), int'(m_y));
            else if (rst) check("y_in_reset", int'(y), 0);
            if (ack != 4'b0) begin
                for (int i = 0; i < 4; i++)
                    if (ack[i]) ack_idx_q.push_back(i);
                ack_y_q.push_back(int'(y));
                ack_cyc_q.push_back(cyc);
            end
            if (gnt != 4'b0 && prev_gnt == 4'b0) gnt_cyc_q.push_back(cyc);
            prev_gnt = gnt;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_rec();
        ack_idx_q.delete();
        ack_y_q.delete();
        ack_cyc_q.delete();
        gnt_cyc_q.delete();
    endtask

    task automatic expect_ack(input string name, input int pos, input int idx, input int yv);
        if (pos < ack_idx_q.size()) begin
            check({name, "_idx"}, ack_idx_q[pos], idx);
            check({name, "_y"}, ack_y_q[pos], yv);
        end else begin
            check({name, "_missing"}, ack_idx_q.size(), pos + 1);
        end
    endtask

    initial begin
        int t0;
        int exp_y2[4];
        int exp_w3[5];
        int exp_y3[5];
        exp_y2 = '{1, 1, 0, 0};
        exp_w3 = '{0, 1, 2, 3, 0};
        exp_y3 = '{0, 1, 1, 0, 0};

        rst = 1'b1; req = '0; a_in = '0; b_in = '0; op_in = '0;
        tick(3);
        rst = 1'b0;

        // Single request from requester 0: OR(1,0) = 1.
        clear_rec();
        t0 = cyc;
        req = 4'b0001; a_in = 4'b0001; b_in = 4'b0000; op_in = 8'h00;
        tick(3);
        req = '0;
        tick(2);
        check("t1_ack_count", ack_idx_q.size(), 1);
        expect_ack("t1", 0, 0, 1);
        if (gnt_cyc_q.size() > 0) check("t1_gnt_latency", gnt_cyc_q[0] - t0, 1);
        else check("t1_gnt_missing", gnt_cyc_q.size(), 1);
        if (ack_cyc_q.size() > 0) check("t1_ack_latency", ack_cyc_q[0] - t0, 2);
        else check("t1_ack_latency_missing", ack_cyc_q.size(), 1);
        check("t1_model_ptr", m_ptr, 1);

        // All four opcodes from requester 2 with a=b=1; other op fields are decoys.
        clear_rec();
        for (int o = 0; o < 4; o++) begin
            req = 4'b0100; a_in = 4'b0100; b_in = 4'b0100;
            op_in = 8'hFF;
            op_in[5:4] = 2'(o);
            tick(3);
            req = '0;
            tick(1);
        end
        for (int o = 0; o < 4; o++) expect_ack($sformatf("t2_op%0d", o), o, 2, exp_y2[o]);

        // Contention: all four held from reset.
        rst = 1'b1;
        req = 4'b1111; a_in = 4'b1010; b_in = 4'b0110; op_in = 8'b11_10_01_00;
        tick(2);
        clear_rec();
        rst = 1'b0;
        tick(15);
        req = '0;
        tick(2);
        check("t3_ack_count", ack_idx_q.size(), 5);
        for (int i = 0; i < 5; i++) expect_ack($sformatf("t3_op%0d", i), i, exp_w3[i], exp_y3[i]);
        for (int i = 1; i < 5; i++)
            if (i < ack_cyc_q.size()) check($sformatf("t3_spacing%0d", i), ack_cyc_q[i] - ack_cyc_q[i-1], 3);

        // Wrap: move ptr to 3 via requester 2, then 3 and 0 contend.
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        req = 4'b0100; a_in = '0; b_in = '0; op_in = '0;
        tick(3);
        req = '0;
        tick(1);
        check("t4_model_ptr", m_ptr, 3);
        clear_rec();
        req = 4'b1001; a_in = 4'b1000; b_in = 4'b0000; op_in = 8'h00;
        tick(6);
        req = '0;
        tick(2);
        check("t4_ack_count", ack_idx_q.size(), 2);
        expect_ack("t4_first", 0, 3, 1);
        expect_ack("t4_second", 1, 0, 0);

        // Operands change during EXEC, winner drops req during RESP: XOR(1,1) = 0.
        clear_rec();
        req = 4'b0010; a_in = 4'b0010; b_in = 4'b0010; op_in = 8'b0000_1000;
        tick(1);
        a_in = 4'b0000; op_in = 8'h00;
        tick(1);
        req = '0;
        tick(2);
        check("t5_ack_count", ack_idx_q.size(), 1);
        expect_ack("t5", 0, 1, 0);

        // Reset during EXEC aborts the operation; next grant starts at requester 0.
        clear_rec();
        req = 4'b0100; a_in = 4'b0100; b_in = 4'b0000; op_in = 8'h00;
        tick(1);
        rst = 1'b1;
        req = '0;
        #1;
        check("t6_gnt_in_reset", int'(gnt), 0);
        check("t6_busy_in_reset", int'(busy), 0);
        check("t6_yv_in_reset", int'(y_valid), 0);
        tick(2);
        rst = 1'b0;
        tick(1);
        check("t6_no_ack", ack_idx_q.size(), 0);
        req = 4'b1111; a_in = 4'b0001; b_in = 4'b0000; op_in = 8'h00;
        tick(3);
        req = '0;
        tick(2);
        check("t6_ack_count", ack_idx_q.size(), 1);
        expect_ack("t6_after_reset", 0, 0, 1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
